// File: rtl/imem_stream_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader: FSM state
// encoding, word/checksum geometry and the checksum accumulate helper.
package imem_stream_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int CKSUM_W        = 8;

  // Modulo-256 running sum; a stream is valid when data plus check byte sums to zero.
  function automatic logic [CKSUM_W-1:0] cksum_add(input logic [CKSUM_W-1:0] sum,
                                                   input logic [7:0]         data);
    return sum + data;
  endfunction

endpackage

// File: rtl/imem_stream_loader_if.sv
// Host-side byte stream, instruction memory write port and core control of
// the loader. The loader uses the slave view, the host/bench the master view.
interface imem_stream_loader_if #(
  parameter int ADDR_W = 10
) ();

  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, word_count, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, word_count, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/imem_stream_loader_byte_packer.sv
// Packs stream bytes MSB-first into a 32-bit word. o_last flags that the
// next load completes the word; the index wraps so the next word starts clean.
module imem_stream_loader_byte_packer
  import imem_stream_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_last
);

  logic [1:0]  r_idx;
  logic [31:0] r_shift;

  // Shift each accepted byte in from the bottom so byte 0 ends up in [31:24].
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= {r_shift[23:0], i_byte};
      r_idx   <= r_idx + 2'd1;
    end
  end

  assign o_word = r_shift;
  assign o_last = (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_stream_loader.sv
// Program loader for the MIPS core: streams bytes into instruction memory as
// big-endian words from address 0, verifies a modulo-256 checksum and then
// releases the core hold.
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int MAX_WORDS     = 1024,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input logic                 clock,
  input logic                 reset_n,
  imem_stream_loader_if.slave bus
);

  localparam logic [ADDR_W:0] MAX_CNT = MAX_WORDS[ADDR_W:0];

  state_e             r_state;
  logic [ADDR_W:0]    r_wc;
  logic [ADDR_W:0]    r_wcnt;
  logic [CKSUM_W-1:0] r_sum;
  logic               r_in_ready;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_hold;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_xfer;
  logic               w_idle_like;
  logic               w_pack_clear;
  logic               w_pack_load;
  logic [31:0]        w_word;
  logic               w_last;
  logic [ADDR_W:0]    w_wcnt_next;
  logic [CKSUM_W-1:0] w_sum_next;

  assign w_xfer       = bus.in_valid && r_in_ready;
  assign w_idle_like  = (r_state == ST_IDLE) || (r_state == ST_ERR);
  assign w_pack_clear = bus.start && w_idle_like;
  assign w_pack_load  = w_xfer && (r_state == ST_RECV);
  assign w_wcnt_next  = r_wcnt + 1'b1;
  assign w_sum_next   = cksum_add(r_sum, bus.in_data);

  imem_stream_loader_byte_packer u_packer (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (w_pack_clear),
    .i_load  (w_pack_load),
    .i_byte  (bus.in_data),
    .o_word  (w_word),
    .o_last  (w_last)
  );

  // Loader FSM with counters, checksum and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_wc       <= '0;
      r_wcnt     <= '0;
      r_sum      <= '0;
      r_in_ready <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_hold     <= HOLD_AT_RESET;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (bus.start) begin
            r_hold <= 1'b1;
            r_err  <= 1'b0;
            r_wcnt <= '0;
            r_sum  <= '0;
            r_wc   <= bus.word_count;
            if (bus.word_count > MAX_CNT) begin
              r_state    <= ST_ERR;
              r_err      <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= (bus.word_count == '0) ? ST_CHECK : ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (w_xfer) begin
            r_sum <= w_sum_next;
            if (w_last) begin
              r_state    <= ST_WRITE;
              r_in_ready <= 1'b0;
              r_we       <= 1'b1;
              r_addr     <= r_wcnt[ADDR_W-1:0];
            end
          end
        end
        ST_WRITE: begin
          r_we       <= 1'b0;
          r_in_ready <= 1'b1;
          r_wcnt     <= w_wcnt_next;
          r_state    <= (w_wcnt_next == r_wc) ? ST_CHECK : ST_RECV;
        end
        ST_CHECK: begin
          if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (w_sum_next == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hold  <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_we       <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = w_word;
  assign bus.cpu_hold   = r_hold;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench for imem_stream_loader: table of loads checked against a byte-list
// model of the expected memory image and checksum outcome, plus hand-written
// reset-mid-load and oversize sequences.
module tb_imem_stream_loader;

  localparam int MAXW = 1024;

  logic clk;
  logic rst_n;

  imem_stream_loader_if #(.ADDR_W(10)) bus ();

  imem_stream_loader #(
    .ADDR_W        (10),
    .MAX_WORDS     (MAXW),
    .HOLD_AT_RESET (1'b1)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, got, exp);
    end
  endfunction

  // Observation of the DUT, sampled on the falling edge.
  int          cyc      = 0;
  int          hs_cnt   = 0;
  int          last_hs  = -10;
  int          done_cnt = 0;
  int          rdy_cnt  = 0;
  logic [9:0]  got_addr[$];
  logic [31:0] got_data[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.imem_we) begin
      chk("we_after_word_bytes", hs_cnt, 4 * (got_addr.size() + 1));
      chk("we_latency", cyc - last_hs, 1);
      got_addr.push_back(bus.imem_addr);
      got_data.push_back(bus.imem_wdata);
    end
    if (bus.in_valid && bus.in_ready) begin
      hs_cnt++;
      last_hs = cyc;
    end
    if (bus.done) done_cnt++;
    if (bus.in_ready) rdy_cnt++;
  end

  typedef struct {
    int         wc;
    bit         fixed;
    int         ckmode;   // 0: use ck, 1: correct checksum, 2: wrong checksum
    logic [7:0] ck;
    int         idle;     // percent chance of an idle cycle before each byte
    bit         exp_ok;
    int         inj;      // byte index before which a stray start is pulsed, -1 none
  } vec_t;

  localparam int NV = 11;
  vec_t       tv[NV];
  logic [7:0] fix_b[8];

  task automatic pulse_start(input int wc, input bit clear_mon);
    bus.start      = 1'b1;
    bus.word_count = 11'(wc);
    if (clear_mon) begin
      got_addr.delete();
      got_data.delete();
      hs_cnt   = 0;
      last_hs  = -10;
      done_cnt = 0;
      rdy_cnt  = 0;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle_pct, output bit ok);
    bit hs;
    while (idle_pct > 0 && $urandom_range(99) < idle_pct) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_imem_we"}, bus.imem_we, 0);
    chk({tag, "_imem_addr"}, bus.imem_addr, 0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_cpu_hold"}, bus.cpu_hold, 1);
  endtask

  task automatic run_load(input vec_t v);
    logic [7:0]  d[$];
    logic [7:0]  b;
    logic [7:0]  ck;
    logic [31:0] w;
    int          s;
    int          nw;
    bit          ok;
    s = 0;
    for (int k = 0; v.wc <= MAXW && k < 4 * v.wc; k++) begin
      b = v.fixed ? fix_b[k % 8] : 8'($urandom);
      d.push_back(b);
      s += int'(b);
    end
    case (v.ckmode)
      1:       ck = 8'(-s);
      2:       ck = 8'(-s) + 8'($urandom_range(1, 255));
      default: ck = v.ck;
    endcase

    pulse_start(v.wc, 1'b1);
    @(negedge clk);
    if (v.wc > MAXW) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      repeat (8) @(negedge clk);
      chk("oversize_err", bus.err, 1);
      chk("oversize_hold", bus.cpu_hold, 1);
      chk("oversize_busy", bus.busy, 0);
      chk("oversize_in_ready_cycles", rdy_cnt, 0);
      chk("oversize_writes", got_addr.size(), 0);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    chk("start_err_clear", bus.err, 0);
    chk("start_hold", bus.cpu_hold, 1);
    chk("start_busy", bus.busy, 1);
    @(posedge clk);
    #1;

    foreach (d[i]) begin
      if (i == v.inj) pulse_start(5, 1'b0);
      send_byte(d[i], v.idle, ok);
      if (!ok) begin
        chk("data_handshake_timeout", 0, 1);
        return;
      end
    end
    send_byte(ck, v.idle, ok);
    if (!ok) begin
      chk("cksum_handshake_timeout", 0, 1);
      return;
    end

    @(negedge clk);
    chk("end_done", bus.done, v.exp_ok);
    chk("end_err", bus.err, !v.exp_ok);
    chk("end_hold", bus.cpu_hold, !v.exp_ok);
    chk("end_busy", bus.busy, v.exp_ok);
    chk("end_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("after_done", bus.done, 0);
    chk("after_busy", bus.busy, 0);
    chk("after_hold", bus.cpu_hold, !v.exp_ok);
    chk("after_err", bus.err, !v.exp_ok);
    chk("done_count", done_cnt, v.exp_ok);
    chk("write_count", got_addr.size(), v.wc);
    nw = (got_addr.size() < v.wc) ? got_addr.size() : v.wc;
    for (int k = 0; k < nw; k++) begin
      w = {d[4*k], d[4*k+1], d[4*k+2], d[4*k+3]};
      chk("write_addr", got_addr[k], k);
      chk("write_data", got_data[k], w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset();
    bit ok;
    pulse_start(2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_byte(fix_b[i], 0, ok);
      if (!ok) begin
        chk("midrst_handshake_timeout", 0, 1);
        break;
      end
    end
    chk("midrst_writes_before", got_addr.size(), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;

    fix_b[0] = 8'h20; fix_b[1] = 8'h08; fix_b[2] = 8'h00; fix_b[3] = 8'h05;
    fix_b[4] = 8'h20; fix_b[5] = 8'h09; fix_b[6] = 8'h00; fix_b[7] = 8'h07;

    // Fixed stream sums to 0x5D, so 0xA3 is the only passing check byte.
    tv[0]  = '{2,    1'b1, 0, 8'hA3, 0,  1'b1, -1};
    tv[1]  = '{2,    1'b1, 0, 8'h7E, 0,  1'b0, -1};
    tv[2]  = '{2,    1'b1, 0, 8'hA3, 0,  1'b1, -1};
    tv[3]  = '{2,    1'b1, 0, 8'hA3, 50, 1'b1, -1};
    tv[4]  = '{0,    1'b0, 0, 8'h00, 0,  1'b1, -1};
    tv[5]  = '{0,    1'b0, 0, 8'h01, 0,  1'b0, -1};
    tv[6]  = '{1025, 1'b0, 0, 8'h00, 0,  1'b0, -1};
    tv[7]  = '{2,    1'b1, 0, 8'hA3, 0,  1'b1, 2};
    tv[8]  = '{7,    1'b0, 1, 8'h00, 30, 1'b1, -1};
    tv[9]  = '{4,    1'b0, 2, 8'h00, 20, 1'b0, -1};
    tv[10] = '{MAXW, 1'b0, 1, 8'h00, 0,  1'b1, -1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_load(tv[i]);
      if (i == 3) begin
        mid_reset();
        run_load(tv[0]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
